// File: rtl/seq_shift_unit_if.sv
// Handshake and data bundle between the multiplier controller and the shift unit.
interface seq_shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic             serial_in;
  logic [WIDTH-1:0] dout;
  logic             carry_out;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, din, serial_in,
    input  dout, carry_out, busy, done
  );

  modport slave (
    input  start, mode, amount, din, serial_in,
    output dout, carry_out, busy, done
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Sequential shift/rotate unit: load once, then shift one bit per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; dout/carry_out hold the last result
// S_SHIFT | one single-bit shift per clock until the count runs out
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  seq_shift_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       mode_q,  mode_d;
  logic             carry_q, carry_d;

  // Next-state and datapath: load on accepted start, one shift per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.din;
          cnt_d   = bus.amount;
          mode_d  = bus.mode;
          carry_d = 1'b0;
          state_d = (bus.amount != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        case (mode_q)
          M_SLL: begin
            shreg_d = {shreg_q[WIDTH-2:0], bus.serial_in};
            carry_d = shreg_q[WIDTH-1];
          end
          M_SRL: begin
            shreg_d = {bus.serial_in, shreg_q[WIDTH-1:1]};
            carry_d = shreg_q[0];
          end
          M_SRA: begin
            shreg_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            carry_d = shreg_q[0];
          end
          M_ROL: begin
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            carry_d = shreg_q[WIDTH-1];
          end
          default: ;
        endcase
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any run without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      mode_q  <= M_SLL;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
    end
  end

  assign bus.dout      = shreg_q;
  assign bus.carry_out = carry_q;
  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: vector table plus abort/ignore sequences.
module tb_seq_shift_unit;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  seq_shift_unit_if #(.WIDTH(8), .AMT_W(3)) bus ();

  seq_shift_unit #(.WIDTH(8), .AMT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] mode;
    logic [2:0] amt;
    logic [7:0] din;
    logic       sin;
    logic [7:0] exp_d;
    logic       exp_c;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation in the current cycle (c) and follow it to completion.
  task automatic run(input logic [1:0] m, input logic [2:0] n, input logic [7:0] d,
                     input logic s, input logic noise, input logic [7:0] exp_d,
                     input logic exp_c, input string name);
    int ni = int'(n);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    logic [7:0] d_at_done = 8'h00;
    logic       c_at_done = 1'b0;
    bus.start = 1'b1; bus.mode = m; bus.amount = n; bus.din = d; bus.serial_in = s;
    for (int k = 1; k <= ni + 3; k++) begin
      tick();
      if (noise && k <= 3) begin
        bus.start = 1'b1; bus.din = 8'hFF; bus.mode = ~m; bus.amount = ~n;
      end else begin
        bus.start = 1'b0; bus.din = 8'h00;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_at   = k;
        d_at_done = bus.dout;
        c_at_done = bus.carry_out;
      end
    end
    chk({name, " dout@done"}, 32'(d_at_done), 32'(exp_d));
    chk({name, " carry@done"}, 32'(c_at_done), 32'(exp_c));
    chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(ni));
    chk({name, " done_cycle"}, 32'(done_at), 32'(ni + 1));
    chk({name, " done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, " dout_hold"}, 32'(bus.dout), 32'(exp_d));
    chk({name, " carry_hold"}, 32'(bus.carry_out), 32'(exp_c));
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{2'b00, 3'd2, 8'hAD, 1'b0, 8'hB4, 1'b0};  // SLL
    vecs[1] = '{2'b10, 3'd3, 8'h96, 1'b0, 8'hF2, 1'b1};  // SRA
    vecs[2] = '{2'b11, 3'd4, 8'hA5, 1'b0, 8'h5A, 1'b0};  // ROL
    vecs[3] = '{2'b11, 3'd7, 8'h5A, 1'b0, 8'h2D, 1'b1};  // ROL by 7: last bit out is 1
    vecs[4] = '{2'b00, 3'd0, 8'h3C, 1'b1, 8'h3C, 1'b0};  // n=0 clears prior carry
    vecs[5] = '{2'b01, 3'd7, 8'h01, 1'b1, 8'hFE, 1'b0};  // SRL fill with ones
    vecs[6] = '{2'b10, 3'd7, 8'h80, 1'b0, 8'hFF, 1'b0};  // SRA spreads sign
    vecs[7] = '{2'b00, 3'd7, 8'hFF, 1'b0, 8'h80, 1'b1};  // SLL long run

    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'b00; bus.amount = 3'd0; bus.din = 8'h00; bus.serial_in = 1'b0;
    tick(); tick();
    chk("reset dout", 32'(bus.dout), 32'h0);
    chk("reset carry", 32'(bus.carry_out), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run(vecs[i].mode, vecs[i].amt, vecs[i].din, vecs[i].sin, 1'b0,
          vecs[i].exp_d, vecs[i].exp_c, $sformatf("vec%0d", i));

    // start re-asserted while shifting must be ignored
    run(2'b00, 3'd5, 8'h3B, 1'b1, 1'b1, 8'h7F, 1'b1, "sll_ignore_start");

    // reset in cycle c+2 of an SRA n=6 run
    bus.start = 1'b1; bus.mode = 2'b10; bus.amount = 3'd6; bus.din = 8'h96; bus.serial_in = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort dout", 32'(bus.dout), 32'h0);
    chk("abort carry", 32'(bus.carry_out), 32'h0);
    chk("abort busy", 32'(bus.busy), 32'h0);
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done || bus.busy) done_seen++;
      tick();
    end
    chk("abort no_done", 32'(done_seen), 32'd0);
    run(2'b00, 3'd1, 8'h81, 1'b0, 1'b0, 8'h02, 1'b1, "sll_after_abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
